truth_table_sweeper: RTL

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_pkg.sv | 16 +
 rtl/tt_lut.sv | 35 +++
 rtl/truth_table_sweeper.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/truth_table_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and the
// supported range of logic-input counts.
package truth_table_pkg;

   // Smallest and largest number of logic inputs the sweeper is built for.
   localparam int N_IN_MIN = 2;
   localparam int N_IN_MAX = 6;

   // Sweeper control states. The encoding is visible on the debug port.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/tt_lut.sv
// Truth-table storage: 2**N_IN x 1 bit, one synchronous write port and two
// combinational read ports (one for the sweep, one for direct evaluation).
module tt_lut #(
   parameter int                 N_IN = 3,
   parameter logic [2**N_IN-1:0] INIT = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [N_IN-1:0] waddr,
   input  logic            wdata,
   input  logic [N_IN-1:0] sweep_addr,
   output logic            sweep_data,
   input  logic [N_IN-1:0] direct_addr,
   output logic            direct_data
);

   localparam int DEPTH = 2**N_IN;

   logic [DEPTH-1:0] mem;

   // Table contents: reset reloads the initial image, otherwise one bit per write.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= INIT;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Reads see the table as it stands before any write on this edge.
   assign sweep_data  = mem[sweep_addr];
   assign direct_data = mem[direct_addr];

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: a small LUT loaded serially, evaluated directly through
// in_vec, and swept row by row over a valid/ready output stream while
// counting the rows whose value is 1.
//
// Output handshake: a row transfers on a rising clock edge where out_valid and
// out_ready are both high. out_valid never drops and out_row/out_x never change
// while a row waits for out_ready; only a transfer or reset moves the stream on.
module truth_table_sweeper
   import truth_table_pkg::*;
#(
   parameter int                 N_IN     = 3,
   parameter logic [2**N_IN-1:0] LUT_INIT = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_en,
   input  logic            load_bit,
   input  logic            start,
   input  logic [N_IN-1:0] in_vec,
   output logic            x_direct,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N_IN-1:0] out_row,
   output logic            out_x,
   output logic            busy,
   output logic            done,
   output logic [N_IN:0]   ones_count,
   output logic [1:0]      state_dbg
);

   localparam logic [N_IN-1:0] LAST_ROW = '1;

   state_t          state;
   state_t          state_nxt;
   logic [N_IN-1:0] ld_ptr;
   logic [N_IN-1:0] row_cnt;
   logic            lut_we;
   logic            sweep_x;
   logic            direct_x;
   logic            start_accept;
   logic            row_accept;
   logic            last_row;

   // Table storage; the write port is only opened while idle.
   tt_lut #(
      .N_IN (N_IN),
      .INIT (LUT_INIT)
   ) u_lut (
      .clk         (clk),
      .rst         (rst),
      .we          (lut_we),
      .waddr       (ld_ptr),
      .wdata       (load_bit),
      .sweep_addr  (row_cnt),
      .sweep_data  (sweep_x),
      .direct_addr (in_vec),
      .direct_data (direct_x)
   );

   // A load on the same cycle as start wins; start is dropped.
   assign start_accept = (state == ST_IDLE) && start && !load_en;
   assign row_accept   = out_valid && out_ready;
   assign last_row     = (row_cnt == LAST_ROW);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start_accept) begin
               state_nxt = ST_SWEEP;
            end
         end
         ST_SWEEP: begin
            if (row_accept && last_row) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State-decoded outputs; row data is forced to zero outside SWEEP.
   always_comb begin
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      out_row   = '0;
      out_x     = 1'b0;
      lut_we    = 1'b0;
      case (state)
         ST_IDLE: begin
            lut_we = load_en;
         end
         ST_SWEEP: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_row   = row_cnt;
            out_x     = sweep_x;
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            lut_we = 1'b0;
         end
      endcase
   end

   assign state_dbg = state;

   // Serial load pointer: advances only on an accepted write, wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_ptr <= '0;
      end else if (lut_we) begin
         ld_ptr <= ld_ptr + 1'b1;
      end
   end

   // Row counter: rewinds on start, steps on each transferred row but the last.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt <= '0;
      end else if (start_accept) begin
         row_cnt <= '0;
      end else if (row_accept && !last_row) begin
         row_cnt <= row_cnt + 1'b1;
      end
   end

   // Ones counter: cleared on start, held from DONE until the next start.
   always_ff @(posedge clk) begin
      if (rst) begin
         ones_count <= '0;
      end else if (start_accept) begin
         ones_count <= '0;
      end else if (row_accept) begin
         ones_count <= ones_count + {{N_IN{1'b0}}, sweep_x};
      end
   end

   // Direct evaluation register, one cycle behind in_vec, read-before-write.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_direct <= 1'b0;
      end else begin
         x_direct <= direct_x;
      end
   end

endmodule
